// File: rtl/pueo_thresh_pkg.sv
// Shared defaults, address layout and compare-width helpers for the PUEO threshold bank.
package pueo_thresh_pkg;

  localparam int NCHAN_DEF = 8;
  localparam int ENV_W_DEF = 18;
  localparam int THR_W_DEF = 18;

  typedef enum logic {
    SEL_MAIN = 1'b0,
    SEL_SUB  = 1'b1
  } thr_sel_e;

  // Address is {sel, channel}; sel sits just above the channel field.
  function automatic int sel_pos(input int nchan);
    return $clog2(nchan);
  endfunction

  function automatic int addr_w(input int nchan);
    return $clog2(nchan) + 1;
  endfunction

  function automatic int addr_chan(input int addr, input int sel_bit);
    return addr & ((1 << sel_bit) - 1);
  endfunction

  // Wide enough that env - thr - 1 never overflows for any operand values.
  function automatic int cmp_width(input int env_w, input int thr_w);
    return ((env_w + 1 > thr_w) ? env_w + 1 : thr_w) + 1;
  endfunction

  function automatic logic [63:0] thr_reset(input int thr_w);
    return (64'd1 << (thr_w - 1)) - 64'd1;
  endfunction

endpackage

// File: rtl/pueo_thresh_chan.sv
// One channel: active main/sub thresholds, envelope stage, two comparators and
// the registered, masked trigger outputs.
module pueo_thresh_chan
  import pueo_thresh_pkg::*;
#(
  parameter int ENV_W = ENV_W_DEF,
  parameter int THR_W = THR_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [ENV_W-1:0] env_i,
  input  logic             load_i,
  input  logic [THR_W-1:0] main_stage_i,
  input  logic [THR_W-1:0] sub_stage_i,
  input  logic             mask_i,
  output logic             trig_main_o,
  output logic             trig_sub_o
);

  localparam int CW = cmp_width(ENV_W, THR_W);
  localparam logic [THR_W-1:0] THR_RST = THR_W'(thr_reset(THR_W));
  localparam logic signed [CW-1:0] ONE = {{(CW-1){1'b0}}, 1'b1};

  logic [ENV_W-1:0] env_q, env_d;
  logic [THR_W-1:0] main_act_q, main_act_d;
  logic [THR_W-1:0] sub_act_q, sub_act_d;
  logic             trig_main_q, trig_main_d;
  logic             trig_sub_q, trig_sub_d;

  logic signed [CW-1:0] env_x, main_x, sub_x;
  logic signed [CW-1:0] main_diff, sub_diff;

  // Trigger when env > thr, i.e. env - thr - 1 is non-negative.
  always_comb begin
    env_d      = env_i;
    main_act_d = load_i ? main_stage_i : main_act_q;
    sub_act_d  = load_i ? sub_stage_i : sub_act_q;

    env_x  = {{(CW-ENV_W){1'b0}}, env_q};
    main_x = {{(CW-THR_W){main_act_q[THR_W-1]}}, main_act_q};
    sub_x  = {{(CW-THR_W){sub_act_q[THR_W-1]}}, sub_act_q};

    main_diff = env_x - main_x - ONE;
    sub_diff  = env_x - sub_x - ONE;

    trig_main_d = ~main_diff[CW-1] & ~mask_i;
    trig_sub_d  = ~sub_diff[CW-1] & ~mask_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      env_q       <= '0;
      main_act_q  <= THR_RST;
      sub_act_q   <= THR_RST;
      trig_main_q <= 1'b0;
      trig_sub_q  <= 1'b0;
    end else begin
      env_q       <= env_d;
      main_act_q  <= main_act_d;
      sub_act_q   <= sub_act_d;
      trig_main_q <= trig_main_d;
      trig_sub_q  <= trig_sub_d;
    end
  end

  assign trig_main_o = trig_main_q;
  assign trig_sub_o  = trig_sub_q;

endmodule

// File: rtl/pueo_threshold_bank_v3.sv
// NCHAN-channel main/subthreshold trigger bank with staged, atomically updated thresholds.
// Define THRESH_SCALER_EN to build per-channel gated trigger-rate scalers.
module pueo_threshold_bank_v3
  import pueo_thresh_pkg::*;
#(
  parameter int NCHAN = NCHAN_DEF,
  parameter int ENV_W = ENV_W_DEF,
  parameter int THR_W = THR_W_DEF
`ifdef THRESH_SCALER_EN
  ,
  parameter int SCAL_W    = 16,
  parameter int GATE_CLKS = 1000000
`endif
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NCHAN*ENV_W-1:0]   envelope_i,
  input  logic [THR_W-1:0]         thresh_dat_i,
  input  logic [addr_w(NCHAN)-1:0] thresh_addr_i,
  input  logic                     thresh_wr_i,
  input  logic                     thresh_update_i,
  input  logic [NCHAN-1:0]         mask_i,
  output logic [NCHAN-1:0]         trig_main_o,
  output logic [NCHAN-1:0]         trig_sub_o,
  output logic                     update_done_o
`ifdef THRESH_SCALER_EN
  ,
  input  logic [addr_w(NCHAN)-1:0] scal_addr_i,
  output logic [SCAL_W-1:0]        scal_dat_o,
  output logic                     scal_valid_o
`endif
);

  localparam int SEL_POS = sel_pos(NCHAN);
  localparam logic [THR_W-1:0] THR_RST = THR_W'(thr_reset(THR_W));

  logic [THR_W-1:0] stage_main_q [NCHAN];
  logic [THR_W-1:0] stage_main_d [NCHAN];
  logic [THR_W-1:0] stage_sub_q  [NCHAN];
  logic [THR_W-1:0] stage_sub_d  [NCHAN];
  logic             upd_q, upd_d;
  logic             done_q, done_d;
  int               wr_chan;
  thr_sel_e         wr_sel;

  // The update strobe is delayed a cycle so a write in the same cycle reaches
  // staging before the active copy; done marks the first cycle the comparators
  // see the new values.
  always_comb begin
    wr_chan = addr_chan(int'(thresh_addr_i), SEL_POS);
    wr_sel  = thr_sel_e'(thresh_addr_i[SEL_POS]);
    for (int n = 0; n < NCHAN; n++) begin
      stage_main_d[n] = stage_main_q[n];
      stage_sub_d[n]  = stage_sub_q[n];
      if (thresh_wr_i && wr_chan == n) begin
        if (wr_sel == SEL_SUB) stage_sub_d[n] = thresh_dat_i;
        else                   stage_main_d[n] = thresh_dat_i;
      end
    end
    upd_d  = thresh_update_i;
    done_d = upd_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int n = 0; n < NCHAN; n++) begin
        stage_main_q[n] <= THR_RST;
        stage_sub_q[n]  <= THR_RST;
      end
      upd_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      for (int n = 0; n < NCHAN; n++) begin
        stage_main_q[n] <= stage_main_d[n];
        stage_sub_q[n]  <= stage_sub_d[n];
      end
      upd_q  <= upd_d;
      done_q <= done_d;
    end
  end

  assign update_done_o = done_q;

  for (genvar g = 0; g < NCHAN; g++) begin : g_chan
    pueo_thresh_chan #(
      .ENV_W (ENV_W),
      .THR_W (THR_W)
    ) u_chan (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .env_i        (envelope_i[g*ENV_W +: ENV_W]),
      .load_i       (upd_q),
      .main_stage_i (stage_main_q[g]),
      .sub_stage_i  (stage_sub_q[g]),
      .mask_i       (mask_i[g]),
      .trig_main_o  (trig_main_o[g]),
      .trig_sub_o   (trig_sub_o[g])
    );
  end

`ifdef THRESH_SCALER_EN
  localparam int NCNT = 2 * NCHAN;
  localparam int GW   = (GATE_CLKS > 1) ? $clog2(GATE_CLKS) : 1;
  localparam logic [GW-1:0]     GATE_LAST = GW'(GATE_CLKS - 1);
  localparam logic [SCAL_W-1:0] SCAL_MAX  = '1;

  logic [GW-1:0]     gate_q, gate_d;
  logic [SCAL_W-1:0] cnt_q   [NCNT];
  logic [SCAL_W-1:0] cnt_d   [NCNT];
  logic [SCAL_W-1:0] latch_q [NCNT];
  logic [SCAL_W-1:0] latch_d [NCNT];
  logic [SCAL_W-1:0] scal_dat_q, scal_dat_d;
  logic              scal_valid_q, scal_valid_d;
  logic              gate_wrap;
  logic [NCNT-1:0]   trig_all;
  int                rd_chan;
  thr_sel_e          rd_sel;

  // Counter index: main channels first, subthreshold channels above them.
  // A trigger seen in the wrap cycle seeds the next gate's count.
  always_comb begin
    trig_all     = {trig_sub_o, trig_main_o};
    gate_wrap    = (gate_q == GATE_LAST);
    gate_d       = gate_wrap ? '0 : gate_q + GW'(1'b1);
    scal_valid_d = gate_wrap;
    for (int i = 0; i < NCNT; i++) begin
      cnt_d[i]   = cnt_q[i];
      latch_d[i] = latch_q[i];
      if (gate_wrap) begin
        latch_d[i] = cnt_q[i];
        cnt_d[i]   = SCAL_W'(trig_all[i]);
      end else if (trig_all[i] && cnt_q[i] != SCAL_MAX) begin
        cnt_d[i] = cnt_q[i] + SCAL_W'(1'b1);
      end
    end

    rd_chan    = addr_chan(int'(scal_addr_i), SEL_POS);
    rd_sel     = thr_sel_e'(scal_addr_i[SEL_POS]);
    scal_dat_d = '0;
    for (int n = 0; n < NCHAN; n++) begin
      if (rd_chan == n) scal_dat_d = (rd_sel == SEL_SUB) ? latch_q[NCHAN+n] : latch_q[n];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      gate_q       <= '0;
      scal_dat_q   <= '0;
      scal_valid_q <= 1'b0;
      for (int i = 0; i < NCNT; i++) begin
        cnt_q[i]   <= '0;
        latch_q[i] <= '0;
      end
    end else begin
      gate_q       <= gate_d;
      scal_dat_q   <= scal_dat_d;
      scal_valid_q <= scal_valid_d;
      for (int i = 0; i < NCNT; i++) begin
        cnt_q[i]   <= cnt_d[i];
        latch_q[i] <= latch_d[i];
      end
    end
  end

  assign scal_dat_o   = scal_dat_q;
  assign scal_valid_o = scal_valid_q;
`endif

endmodule
